// File: rtl/assertion_monitor.sv
// Runtime property monitor: counts evaluated cycles and failures of an
// external checker's pass output, captures the first failure, and latches FAILED.
module assertion_monitor #(
    parameter int unsigned FAIL_LIMIT = 1,
    parameter int unsigned SW         = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          arm,
    input  logic          clear,
    input  logic          antecedent,
    input  logic          valid,
    input  logic [SW-1:0] sample,
    output logic [1:0]    state,
    output logic          fail,
    output logic          fail_pulse,
    output logic [7:0]    fail_count,
    output logic [15:0]   check_count,
    output logic [15:0]   cycle_count,
    output logic [SW-1:0] first_fail_sample,
    output logic [15:0]   first_fail_cycle
);

    localparam int unsigned FCW = 8;
    localparam int unsigned CW  = 16;
    localparam logic [FCW-1:0] FC_MAX = '1;
    localparam logic [CW-1:0]  C_MAX  = '1;
    localparam logic [FCW-1:0] LIMIT  = FCW'(FAIL_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ARMED  = 2'b01,
        ST_FAILED = 2'b10,
        ST_BAD    = 2'b11
    } state_t;

    state_t         state_q, state_nxt;
    logic           fail_nxt, pulse_nxt;
    logic [FCW-1:0] fc_nxt;
    logic [CW-1:0]  chk_nxt, cyc_nxt, ffc_nxt;
    logic [SW-1:0]  ffs_nxt;

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            fail              <= 1'b0;
            fail_pulse        <= 1'b0;
            fail_count        <= '0;
            check_count       <= '0;
            cycle_count       <= '0;
            first_fail_sample <= '0;
            first_fail_cycle  <= '0;
        end else begin
            state_q           <= state_nxt;
            fail              <= fail_nxt;
            fail_pulse        <= pulse_nxt;
            fail_count        <= fc_nxt;
            check_count       <= chk_nxt;
            cycle_count       <= cyc_nxt;
            first_fail_sample <= ffs_nxt;
            first_fail_cycle  <= ffc_nxt;
        end
    end

    assign state = state_q;

    // Next-state and counter update; clear beats arm, arm skips evaluation
    always_comb begin
        state_nxt = state_q;
        fail_nxt  = fail;
        pulse_nxt = 1'b0;
        fc_nxt    = fail_count;
        chk_nxt   = check_count;
        cyc_nxt   = cycle_count;
        ffs_nxt   = first_fail_sample;
        ffc_nxt   = first_fail_cycle;

        if (clear || arm) begin
            state_nxt = clear ? ST_IDLE : ST_ARMED;
            fail_nxt  = 1'b0;
            fc_nxt    = '0;
            chk_nxt   = '0;
            cyc_nxt   = '0;
            ffs_nxt   = '0;
            ffc_nxt   = '0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ARMED: begin
                    cyc_nxt = (cycle_count == C_MAX) ? C_MAX : cycle_count + 16'd1;
                    if (antecedent) begin
                        chk_nxt = (check_count == C_MAX) ? C_MAX : check_count + 16'd1;
                        if (!valid) begin
                            pulse_nxt = 1'b1;
                            fc_nxt    = (fail_count == FC_MAX) ? FC_MAX : fail_count + 8'd1;
                            // fail_count is zero only before the first failure since arm
                            if (fail_count == '0) begin
                                ffs_nxt = sample;
                                ffc_nxt = cycle_count;
                            end
                            if (fc_nxt == LIMIT) begin
                                state_nxt = ST_FAILED;
                                fail_nxt  = 1'b1;
                            end
                        end
                    end
                end
                ST_FAILED: ;
                default: begin
                    state_nxt = ST_IDLE;
                    fail_nxt  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_assertion_monitor.sv
// Self-checking bench: directed vector table, hand sequences and random
// stimulus against a behavioural model, for FAIL_LIMIT=1 and FAIL_LIMIT=3.
module tb_assertion_monitor;

    logic       clk = 1'b0;
    logic       rst_n, arm, clear, antecedent, valid;
    logic [3:0] sample;

    logic [1:0]  st1, st3;
    logic        fail1, fail3, pulse1, pulse3;
    logic [7:0]  fc1, fc3;
    logic [15:0] cc1, cc3, cyc1, cyc3, ffc1, ffc3;
    logic [3:0]  ffs1, ffs3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assertion_monitor #(.FAIL_LIMIT(1), .SW(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .arm(arm), .clear(clear),
        .antecedent(antecedent), .valid(valid), .sample(sample),
        .state(st1), .fail(fail1), .fail_pulse(pulse1), .fail_count(fc1),
        .check_count(cc1), .cycle_count(cyc1),
        .first_fail_sample(ffs1), .first_fail_cycle(ffc1));

    assertion_monitor #(.FAIL_LIMIT(3), .SW(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .arm(arm), .clear(clear),
        .antecedent(antecedent), .valid(valid), .sample(sample),
        .state(st3), .fail(fail3), .fail_pulse(pulse3), .fail_count(fc3),
        .check_count(cc3), .cycle_count(cyc3),
        .first_fail_sample(ffs3), .first_fail_cycle(ffc3));

    // Behavioural model: mode 0 idle, 1 checking, 2 failed; index 0 -> limit 1, 1 -> limit 3
    int m_mode[2], m_fc[2], m_cc[2], m_cyc[2], m_ffs[2], m_ffc[2];
    bit m_fail[2], m_pulse[2], m_cap[2];
    int lim[2] = '{1, 3};

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic void model_step(bit r, bit a, bit c, bit an, bit v, logic [3:0] s);
        for (int k = 0; k < 2; k++) begin
            m_pulse[k] = 1'b0;
            if (!r || c || a) begin
                m_mode[k] = (!r || c) ? 0 : 1;
                m_fail[k] = 1'b0;
                m_cap[k]  = 1'b0;
                m_fc[k] = 0; m_cc[k] = 0; m_cyc[k] = 0; m_ffs[k] = 0; m_ffc[k] = 0;
            end else if (m_mode[k] == 1) begin
                if (an && !v) begin
                    m_pulse[k] = 1'b1;
                    if (!m_cap[k]) begin
                        m_cap[k] = 1'b1;
                        m_ffs[k] = int'(s);
                        m_ffc[k] = m_cyc[k];
                    end
                    m_fc[k] = sat(m_fc[k] + 1, 255);
                    if (m_fc[k] == lim[k]) begin
                        m_mode[k] = 2;
                        m_fail[k] = 1'b1;
                    end
                end
                if (an) m_cc[k] = sat(m_cc[k] + 1, 65535);
                m_cyc[k] = sat(m_cyc[k] + 1, 65535);
            end
        end
    endfunction

    function automatic void check_model();
        chk("m1_state", 32'(st1), 32'(m_mode[0]));
        chk("m1_fail", 32'(fail1), 32'(m_fail[0]));
        chk("m1_pulse", 32'(pulse1), 32'(m_pulse[0]));
        chk("m1_fail_count", 32'(fc1), 32'(m_fc[0]));
        chk("m1_check_count", 32'(cc1), 32'(m_cc[0]));
        chk("m1_cycle_count", 32'(cyc1), 32'(m_cyc[0]));
        chk("m1_ff_sample", 32'(ffs1), 32'(m_ffs[0]));
        chk("m1_ff_cycle", 32'(ffc1), 32'(m_ffc[0]));
        chk("m3_state", 32'(st3), 32'(m_mode[1]));
        chk("m3_fail", 32'(fail3), 32'(m_fail[1]));
        chk("m3_pulse", 32'(pulse3), 32'(m_pulse[1]));
        chk("m3_fail_count", 32'(fc3), 32'(m_fc[1]));
        chk("m3_check_count", 32'(cc3), 32'(m_cc[1]));
        chk("m3_cycle_count", 32'(cyc3), 32'(m_cyc[1]));
        chk("m3_ff_sample", 32'(ffs3), 32'(m_ffs[1]));
        chk("m3_ff_cycle", 32'(ffc3), 32'(m_ffc[1]));
    endfunction

    task automatic step(input bit r, input bit a, input bit c, input bit an, input bit v,
                        input logic [3:0] s, input bit do_chk);
        rst_n = r; arm = a; clear = c; antecedent = an; valid = v; sample = s;
        @(posedge clk);
        #1;
        model_step(r, a, c, an, v, s);
        if (do_chk) check_model();
    endtask

    typedef struct {
        bit r, a, c, an, v;
        logic [3:0] s;
        logic [1:0] est;
        bit efail, epulse;
        int efc, ecc, ecyc;
        logic [3:0] effs;
        int effc;
    } vec_t;

    vec_t tbl[12];

    initial begin
        bit f;
        // Expected values for the FAIL_LIMIT=1 instance
        tbl[0]  = '{0,0,0,1,0, 4'd0, 2'd0, 0,0, 0,0,0, 4'd0, 0};
        tbl[1]  = '{1,0,0,1,0, 4'd9, 2'd0, 0,0, 0,0,0, 4'd0, 0};
        tbl[2]  = '{1,1,0,1,0, 4'd0, 2'd1, 0,0, 0,0,0, 4'd0, 0};
        tbl[3]  = '{1,0,0,1,1, 4'd1, 2'd1, 0,0, 0,1,1, 4'd0, 0};
        tbl[4]  = '{1,0,0,1,1, 4'd2, 2'd1, 0,0, 0,2,2, 4'd0, 0};
        tbl[5]  = '{1,0,0,1,0, 4'd5, 2'd2, 1,1, 1,3,3, 4'd5, 2};
        tbl[6]  = '{1,0,0,1,0, 4'd7, 2'd2, 1,0, 1,3,3, 4'd5, 2};
        tbl[7]  = '{1,0,0,0,0, 4'd3, 2'd2, 1,0, 1,3,3, 4'd5, 2};
        tbl[8]  = '{1,1,0,1,0, 4'd3, 2'd1, 0,0, 0,0,0, 4'd0, 0};
        tbl[9]  = '{1,0,0,0,0, 4'd4, 2'd1, 0,0, 0,0,1, 4'd0, 0};
        tbl[10] = '{1,1,1,1,0, 4'd4, 2'd0, 0,0, 0,0,0, 4'd0, 0};
        tbl[11] = '{1,0,0,1,0, 4'd6, 2'd0, 0,0, 0,0,0, 4'd0, 0};

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].r, tbl[i].a, tbl[i].c, tbl[i].an, tbl[i].v, tbl[i].s, 1'b1);
            chk("tbl_state", 32'(st1), 32'(tbl[i].est));
            chk("tbl_fail", 32'(fail1), 32'(tbl[i].efail));
            chk("tbl_pulse", 32'(pulse1), 32'(tbl[i].epulse));
            chk("tbl_fail_count", 32'(fc1), 32'(tbl[i].efc));
            chk("tbl_check_count", 32'(cc1), 32'(tbl[i].ecc));
            chk("tbl_cycle_count", 32'(cyc1), 32'(tbl[i].ecyc));
            chk("tbl_ff_sample", 32'(ffs1), 32'(tbl[i].effs));
            chk("tbl_ff_cycle", 32'(ffc1), 32'(tbl[i].effc));
        end

        // Reset, then failing-looking inputs while idle are ignored
        step(0, 0, 0, 0, 0, 4'd0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 1, 0, 4'(i), 1'b1);
            chk("idle_state", 32'(st1), 32'd0);
            chk("idle_fail_count", 32'(fc1), 32'd0);
            chk("idle_pulse", 32'(pulse1), 32'd0);
        end

        // Six passing evaluations
        step(1, 1, 0, 0, 0, 4'd0, 1'b1);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 1, 1, 4'd1, 1'b1);
        chk("pass_check_count", 32'(cc1), 32'd6);
        chk("pass_cycle_count", 32'(cyc1), 32'd6);
        chk("pass_fail", 32'(fail1), 32'd0);
        chk("pass_state", 32'(st1), 32'd1);

        // Three failures at armed cycles 1, 4, 7 on the limit-3 instance
        step(1, 1, 0, 0, 0, 4'd0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            f = (i == 1 || i == 4 || i == 7);
            step(1, 0, 0, 1, !f, 4'(i + 2), 1'b1);
            chk("l3_pulse", 32'(pulse3), 32'(f));
            if (i == 4) chk("l3_mid_state", 32'(st3), 32'd1);
        end
        chk("l3_state", 32'(st3), 32'd2);
        chk("l3_fail", 32'(fail3), 32'd1);
        chk("l3_fail_count", 32'(fc3), 32'd3);
        chk("l3_ff_sample", 32'(ffs3), 32'd3);
        chk("l3_ff_cycle", 32'(ffc3), 32'd1);
        chk("l3_cycle_frozen", 32'(cyc3), 32'd8);

        // arm and clear together, then reset out of FAILED
        step(1, 1, 0, 0, 0, 4'd0, 1'b1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 1, 4'd2, 1'b1);
        step(1, 1, 1, 1, 0, 4'd2, 1'b1);
        chk("armclr_state", 32'(st1), 32'd0);
        chk("armclr_cycle", 32'(cyc1), 32'd0);
        step(1, 1, 0, 0, 0, 4'd0, 1'b1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 4'hA, 1'b1);
        chk("pre_rst_state", 32'(st3), 32'd2);
        step(0, 0, 0, 1, 0, 4'd0, 1'b1);
        chk("rst_state", 32'(st3), 32'd0);
        chk("rst_fail", 32'(fail3), 32'd0);
        chk("rst_fail_count", 32'(fc3), 32'd0);
        chk("rst_ff_sample", 32'(ffs3), 32'd0);
        step(1, 0, 0, 1, 0, 4'd1, 1'b1);
        chk("post_rst_idle", 32'(fc3), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(99) != 0), ($urandom_range(99) < 3),
                 ($urandom_range(99) < 2), ($urandom_range(1) == 1),
                 ($urandom_range(9) < 7), 4'($urandom), 1'b1);
        end

        // Long vacuous run saturates cycle_count
        step(1, 1, 0, 0, 0, 4'd0, 1'b1);
        for (int i = 0; i < 70000; i++) begin
            step(1, 0, 0, 0, $urandom_range(1) == 1, 4'($urandom), (i % 4096) == 0);
        end
        check_model();
        chk("sat_cycle_count", 32'(cyc1), 32'd65535);
        chk("sat_check_count", 32'(cc1), 32'd0);
        chk("sat_fail_count", 32'(fc1), 32'd0);
        chk("sat_state", 32'(st1), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
